psum_accumulator: RTL and testbench

- Parametrised successor to the fixed 8-lane partial-sum accumulation stage behind the conv_2d / channel_in_accumulation array.
- Accumulates per-pixel partial sums across a run-time number of channel-in passes, using an internal buffer of DEPTH pixel positions.
- On the final pass, emits the finished sums through a valid/ready output FIFO with backpressure.
- Sits between the channel-in adder trees and the quantisation stage (bias/scale/shift).

---
 rtl/psum_accumulator.sv | 227 ++++++++++++++++++++++
 tb/tb_psum_accumulator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates per-pixel, per-lane partial sums across a run-time number of
//   channel-in passes. A DEPTH-entry pixel buffer holds the running sums. On the
//   last pass the finished sums go out through a small valid/ready FIFO.
//
//   Optional build macro: PSUM_SATURATE_EN. When it is defined, each lane clamps
//   to the signed WIDTH_ACC range on every add. When it is not defined, each lane
//   wraps modulo 2**WIDTH_ACC.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   Start             one-cycle pulse: latch config, start a run (IDLE only)
//   Next_Reg          synchronous abort/flush back to IDLE
//   Cfg_Pixel_Num     pixels per pass (1..DEPTH)
//   Cfg_Pass_Num      number of passes (0 is treated as 1)
//   S_Data/S_Valid/S_Ready   incoming partial sums, LANES x WIDTH_IN
//   M_Data/M_Valid/M_Ready   finished sums, LANES x WIDTH_ACC
//   Busy              high outside IDLE
//   Compute_Complete  one-cycle pulse in DONE
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | accepting beats, accumulating
// DRAIN | last beat taken; waiting for pipeline and FIFO to empty
// DONE  | one cycle, Compute_Complete high

module psum_accumulator #(
    parameter int LANES          = 8,
    parameter int WIDTH_IN       = 20,
    parameter int WIDTH_ACC      = 32,
    parameter int ADDR_BITS      = 8,
    parameter int WIDTH_PASS_REG = 10,
    parameter int OUT_FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Start,
    input  logic                          Next_Reg,
    input  logic [ADDR_BITS:0]            Cfg_Pixel_Num,
    input  logic [WIDTH_PASS_REG-1:0]     Cfg_Pass_Num,
    input  logic [LANES*WIDTH_IN-1:0]     S_Data,
    input  logic                          S_Valid,
    output logic                          S_Ready,
    output logic [LANES*WIDTH_ACC-1:0]    M_Data,
    output logic                          M_Valid,
    input  logic                          M_Ready,
    output logic                          Busy,
    output logic                          Compute_Complete
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int FP    = $clog2(OUT_FIFO_DEPTH);
    localparam int CW    = FP + 1;

`ifdef PSUM_SATURATE_EN
    localparam logic [WIDTH_ACC-1:0] SAT_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
    localparam logic [WIDTH_ACC-1:0] SAT_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [ADDR_BITS:0]          cfg_pix;
    logic [WIDTH_PASS_REG-1:0]   cfg_pass_last;
    logic [ADDR_BITS-1:0]        pix_cnt;
    logic [WIDTH_PASS_REG-1:0]   pass_cnt;

    logic                        s1_valid;
    logic [LANES*WIDTH_IN-1:0]   s1_data;
    logic [LANES*WIDTH_ACC-1:0]  s1_buf;
    logic [ADDR_BITS-1:0]        s1_pix;
    logic                        s1_first;
    logic                        s1_last;
    logic [LANES*WIDTH_ACC-1:0]  s2_sum;

    logic [LANES*WIDTH_ACC-1:0]  buf_mem [DEPTH];

    logic [LANES*WIDTH_ACC-1:0]  fifo_mem [OUT_FIFO_DEPTH];
    logic [FP-1:0]               fifo_wr;
    logic [FP-1:0]               fifo_rd;
    logic [CW-1:0]               fifo_cnt;

    logic accept, pix_last, last_pass, credit_ok, in_flight;
    logic buf_we, fwd, push, pop;

    // One lane add. The saturating build computes with one guard bit and
    // clamps when the two top bits disagree.
    function automatic logic [WIDTH_ACC-1:0] lane_add(input logic [WIDTH_ACC-1:0] base,
                                                      input logic [WIDTH_IN-1:0]  din);
        logic signed [WIDTH_ACC-1:0] base_s;
        logic signed [WIDTH_IN-1:0]  din_s;
`ifdef PSUM_SATURATE_EN
        logic signed [WIDTH_ACC:0]   wide;
`endif
        base_s = base;
        din_s  = din;
`ifdef PSUM_SATURATE_EN
        wide = (WIDTH_ACC+1)'(base_s) + (WIDTH_ACC+1)'(din_s);
        if (wide[WIDTH_ACC] != wide[WIDTH_ACC-1])
            return wide[WIDTH_ACC] ? SAT_MIN : SAT_MAX;
        return wide[WIDTH_ACC-1:0];
`else
        return base_s + WIDTH_ACC'(din_s);
`endif
    endfunction

    assign last_pass = (pass_cnt == cfg_pass_last);
    assign pix_last  = ({1'b0, pix_cnt} == (cfg_pix - (ADDR_BITS+1)'(1)));

    // Only beats that will land in the FIFO need a credit. A last-pass beat
    // sitting in stage 1 will push next edge, so it counts against occupancy.
    assign in_flight = s1_valid & s1_last;
    assign credit_ok = ((CW+1)'(fifo_cnt) + (CW+1)'(in_flight)) < (CW+1)'(OUT_FIFO_DEPTH);

    assign S_Ready = (state_q == RUN) && (!last_pass || credit_ok);
    assign accept  = S_Valid & S_Ready;

    assign Busy             = (state_q != IDLE);
    assign Compute_Complete = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (accept && pix_last && last_pass) state_d = DRAIN;
            DRAIN:   if (!s1_valid && (fifo_cnt == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (Next_Reg) state_d = IDLE;
    end

    always_comb begin
        s2_sum = '0;
        for (int i = 0; i < LANES; i++)
            s2_sum[i*WIDTH_ACC +: WIDTH_ACC] =
                lane_add(s1_first ? '0 : s1_buf[i*WIDTH_ACC +: WIDTH_ACC],
                         s1_data[i*WIDTH_IN +: WIDTH_IN]);
    end

    assign buf_we = s1_valid & ~s1_last & ~Next_Reg;
    // Same-edge write and read of one pixel: the memory still holds the old
    // value, so the fresh sum is taken straight from stage 2.
    assign fwd    = buf_we && (s1_pix == pix_cnt);
    assign push   = s1_valid & s1_last;
    assign pop    = M_Valid & M_Ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_pix       <= '0;
            cfg_pass_last <= '0;
            pix_cnt       <= '0;
            pass_cnt      <= '0;
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_buf        <= '0;
            s1_pix        <= '0;
            s1_first      <= 1'b0;
            s1_last       <= 1'b0;
        end else if (Next_Reg) begin
            pix_cnt  <= '0;
            pass_cnt <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (state_q == IDLE && Start) begin
                cfg_pix       <= Cfg_Pixel_Num;
                cfg_pass_last <= (Cfg_Pass_Num == '0) ? '0
                                 : Cfg_Pass_Num - WIDTH_PASS_REG'(1);
                pix_cnt       <= '0;
                pass_cnt      <= '0;
            end else if (accept) begin
                if (pix_last) begin
                    pix_cnt  <= '0;
                    pass_cnt <= pass_cnt + WIDTH_PASS_REG'(1);
                end else begin
                    pix_cnt  <= pix_cnt + ADDR_BITS'(1);
                end
            end
            s1_valid <= accept;
            if (accept) begin
                s1_data  <= S_Data;
                s1_pix   <= pix_cnt;
                s1_first <= (pass_cnt == '0);
                s1_last  <= last_pass;
                s1_buf   <= fwd ? s2_sum : buf_mem[pix_cnt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[s1_pix] <= s2_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < OUT_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (Next_Reg) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr] <= s2_sum;
                fifo_wr           <= fifo_wr + FP'(1);
            end
            if (pop) fifo_rd <= fifo_rd + FP'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign M_Valid = (fifo_cnt != '0);
    assign M_Data  = fifo_mem[fifo_rd];

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

    localparam int LANES = 8;
    localparam int WI    = 20;
    localparam int WA    = 21;
    localparam int AB    = 8;
    localparam int WP    = 10;
    localparam int FD    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 Start, Next_Reg;
    logic [AB:0]          Cfg_Pixel_Num;
    logic [WP-1:0]        Cfg_Pass_Num;
    logic [LANES*WI-1:0]  S_Data;
    logic                 S_Valid, S_Ready;
    logic [LANES*WA-1:0]  M_Data;
    logic                 M_Valid, M_Ready;
    logic                 Busy, Compute_Complete;

    always #5 clk = ~clk;

    psum_accumulator #(
        .LANES(LANES), .WIDTH_IN(WI), .WIDTH_ACC(WA), .ADDR_BITS(AB),
        .WIDTH_PASS_REG(WP), .OUT_FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .Start(Start), .Next_Reg(Next_Reg),
        .Cfg_Pixel_Num(Cfg_Pixel_Num), .Cfg_Pass_Num(Cfg_Pass_Num),
        .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
        .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready),
        .Busy(Busy), .Compute_Complete(Compute_Complete)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [LANES*WA-1:0] outq [$];
    int cc_cnt  = 0;
    int acc_cnt = 0;

    always @(negedge clk) begin
        if (M_Valid && M_Ready) outq.push_back(M_Data);
        if (Compute_Complete) cc_cnt++;
        if (S_Valid && S_Ready) acc_cnt++;
    end

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [LANES*WA-1:0] obs,
                         input logic [LANES*WA-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*WI-1:0] mk_in(input int v, input int v7);
        logic [LANES*WI-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*WI +: WI] = (i == LANES-1) ? v7[WI-1:0] : v[WI-1:0];
        return r;
    endfunction

    function automatic logic [LANES*WA-1:0] mk_out(input int v, input int v7);
        logic [LANES*WA-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*WA +: WA] = (i == LANES-1) ? v7[WA-1:0] : v[WA-1:0];
        return r;
    endfunction

    task automatic start_run(input int pix, input int pass);
        Cfg_Pixel_Num = pix[AB:0];
        Cfg_Pass_Num  = pass[WP-1:0];
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic send(input logic [LANES*WI-1:0] d);
        int t;
        t = 0;
        S_Data  = d;
        S_Valid = 1'b1;
        while (!S_Ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) begin
            chk_i("send_timeout", int'(S_Ready), 1);
        end else begin
            @(posedge clk); #1;
        end
        S_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (Busy && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk_i(tag, int'(Busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cc0, acc0, sat_exp;
        int v3 [3];

        rst = 1'b1; Start = 1'b0; Next_Reg = 1'b0;
        Cfg_Pixel_Num = '0; Cfg_Pass_Num = '0;
        S_Data = '0; S_Valid = 1'b0; M_Ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_i("rst_busy",   int'(Busy), 0);
        chk_i("rst_sready", int'(S_Ready), 0);
        chk_i("rst_mvalid", int'(M_Valid), 0);
        chk_i("rst_cc",     int'(Compute_Complete), 0);
        chk_v("rst_mdata",  M_Data, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single pass, 4 pixels, latency and completion pulse
        base = outq.size(); cc0 = cc_cnt;
        start_run(4, 1);
        chk_i("t1_busy",   int'(Busy), 1);
        chk_i("t1_sready", int'(S_Ready), 1);
        send(mk_in(1, 1));
        chk_i("t1_lat_t1", int'(M_Valid), 0);
        send(mk_in(2, 2));
        chk_i("t1_lat_t2", int'(M_Valid), 1);
        chk_v("t1_first",  M_Data, mk_out(1, 1));
        send(mk_in(3, 3));
        send(mk_in(4, 4));
        chk_i("t1_drain_sready", int'(S_Ready), 0);
        wait_idle("t1_idle");
        chk_i("t1_count", outq.size() - base, 4);
        for (int p = 0; p < 4; p++)
            chk_v("t1_out", outq[base+p], mk_out(p+1, p+1));
        chk_i("t1_cc", cc_cnt - cc0, 1);

        // three passes, two pixels, signed inputs
        base = outq.size(); cc0 = cc_cnt;
        v3[0] = 5; v3[1] = -2; v3[2] = 7;
        start_run(2, 3);
        for (int ps = 0; ps < 3; ps++)
            for (int px = 0; px < 2; px++)
                send(mk_in(v3[ps], -20));
        wait_idle("t2_idle");
        chk_i("t2_count", outq.size() - base, 2);
        chk_v("t2_out0", outq[base],   mk_out(10, -60));
        chk_v("t2_out1", outq[base+1], mk_out(10, -60));
        chk_i("t2_cc", cc_cnt - cc0, 1);

        // backpressure: FIFO credit limits acceptance to 4 beats
        base = outq.size(); acc0 = acc_cnt;
        M_Ready = 1'b0;
        start_run(8, 1);
        for (int i = 0; i < 4; i++) send(mk_in(10+i, 10+i));
        S_Data = mk_in(14, 14); S_Valid = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk_i("t3_sready_low", int'(S_Ready), 0);
        chk_i("t3_accepted",   acc_cnt - acc0, 4);
        chk_i("t3_mvalid",     int'(M_Valid), 1);
        chk_v("t3_hold",       M_Data, mk_out(10, 10));
        M_Ready = 1'b1;
        for (int i = 4; i < 8; i++) send(mk_in(10+i, 10+i));
        wait_idle("t3_idle");
        chk_i("t3_count", outq.size() - base, 8);
        for (int p = 0; p < 8; p++)
            chk_v("t3_order", outq[base+p], mk_out(10+p, 10+p));

        // single pixel, back-to-back beats through the forwarding path
        base = outq.size();
        start_run(1, 4);
        for (int i = 0; i < 4; i++) send(mk_in(1, 1));
        wait_idle("t4_idle");
        chk_i("t4_count", outq.size() - base, 1);
        chk_v("t4_out", outq[base], mk_out(4, 4));

        // abort mid pass 2, then a fresh run must ignore stale buffer data
        base = outq.size(); cc0 = cc_cnt;
        start_run(2, 3);
        send(mk_in(100, 100));
        send(mk_in(100, 100));
        send(mk_in(100, 100));
        Next_Reg = 1'b1;
        @(posedge clk); #1;
        Next_Reg = 1'b0;
        chk_i("t5_busy",   int'(Busy), 0);
        chk_i("t5_mvalid", int'(M_Valid), 0);
        chk_i("t5_sready", int'(S_Ready), 0);
        repeat (5) begin @(posedge clk); #1; end
        chk_i("t5_no_cc", cc_cnt - cc0, 0);
        Start = 1'b1; Next_Reg = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; Next_Reg = 1'b0;
        chk_i("t5_start_vs_next", int'(Busy), 0);
        start_run(2, 2);
        for (int i = 0; i < 4; i++) send(mk_in(3, 3));
        wait_idle("t5_idle");
        chk_i("t5_count", outq.size() - base, 2);
        chk_v("t5_out0", outq[base],   mk_out(6, 6));
        chk_v("t5_out1", outq[base+1], mk_out(6, 6));
        chk_i("t5_cc", cc_cnt - cc0, 1);

        // overflow at WIDTH_ACC=21
`ifdef PSUM_SATURATE_EN
        sat_exp = 1048575;
`else
        sat_exp = -524291;
`endif
        base = outq.size();
        start_run(1, 3);
        for (int i = 0; i < 3; i++) send(mk_in(524287, 524287));
        wait_idle("t6_idle");
        chk_i("t6_count", outq.size() - base, 1);
        chk_v("t6_out", outq[base], mk_out(sat_exp, sat_exp));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
